bot_stream_feeder: RTL and testbench
====================================

# bot_stream_feeder

Drives the input side of the streaming connected-count core and consumes its result side. It accepts bot graphs from an upstream valid/ready stream and issues them under `almostFull` backpressure, tagging the last bot of each batch. Returned `connectCount` values are folded into a per-batch sum of 2^connectCount. `freezeCore` stalls the core whenever the downstream batch-sum sink cannot keep up.

## Interface
Parameters:
- `OUT_QUEUE_DEPTH_LOG2`, 2: log2 of the batch-result queue depth (4 entries).
- `FREEZE_MARGIN`, 2: free entries still left in the result queue at the point where `freezeCore` asserts.
- `INFLIGHT_WIDTH`, 16: width of the outstanding-bot counter.

Ports:
- `clk`  in  1: single clock, shared with the core's `clk`.
- `rstN`  in  1: asynchronous, active-low reset.
- `botValid`  in  1: upstream bot present.
- `botGraph`  in  128: upstream bot graph.
- `botLast`  in  1: this bot closes its batch.
- `botReady`  out  1: upstream handshake.
- `isBotValid`  out  1: to core.
- `graphIn`  out  128: to core.
- `extraDataIn`  out  1: to core; batch-last tag.
- `freezeCore`  out  1: to core.
- `almostFull`  in  1: from core.
- `resultValid`  in  1: from core.
- `connectCount`  in  6: from core.
- `extraDataOut`  in  1: from core; echoed batch-last tag.
- `eccStatus`  in  1: from core.
- `batchSumValid`  out  1: head of the result queue is valid.
- `batchSum`  out  64: sum of 2^connectCount over the batch.
- `batchBots`  out  32: bot count of the batch (see Configuration).
- `batchSumReady`  in  1: downstream accept.
- `inFlight`  out  INFLIGHT_WIDTH: bots issued but not yet returned.
- `protocolError`  out  1: sticky.
- `eccError`  out  1: sticky.

## Operation
- Issue path:
  - `botReady = !almostFull && !freezeCore`, combinational from `almostFull` and the `freezeCore` register.
  - On `botValid && botReady`, register `isBotValid=1`, `graphIn=botGraph`, `extraDataIn=botLast`. Otherwise `isBotValid=0` and `graphIn`/`extraDataIn` hold their last values.
  - `isBotValid` is never 1 in a cycle where `freezeCore` is 1, because the core discards bots presented while frozen.
- In-flight counter: +1 on an issue, −1 on `resultValid`, unchanged when both happen in the same cycle.
- `resultValid` while `inFlight==0`: set `protocolError`, counter stays at 0 (no wrap).
- Issue while `inFlight` is all-ones: set `protocolError`, counter saturates.
- Accumulator:
  - On each `resultValid`: `acc += 64'd1 << connectCount`. `connectCount` ranges 0..63, so the shift always fits; the sum wraps mod 2^64.
  - `bots += 1` on each `resultValid`.
- Batch close: a `resultValid` with `extraDataOut=1` pushes {acc including this result, bots including this result} into the queue, then clears acc and bots to 0 in the same cycle. A single-bot batch is legal.
- Queue:
  - FIFO of 2^OUT_QUEUE_DEPTH_LOG2 entries.
  - `batchSumValid` = not empty; head fields drive `batchSum` and `batchBots`.
  - Pop on `batchSumValid && batchSumReady`. Push and pop in the same cycle are allowed, including when the queue is full.
  - A push into a full queue without a simultaneous pop drops the entry and sets `protocolError`.
- Freeze: `freezeCore` is registered and equals 1 when free entries ≤ FREEZE_MARGIN. The margin absorbs the core's 2-cycle result drain after a freeze.
- `eccError` is set on any `eccStatus=1` and cleared only by reset.

## Timing
- Reset (async assert, sync deassert handled upstream) clears all of the following to 0: `isBotValid`, `graphIn`, `extraDataIn`, `freezeCore`, `botReady`-driving state, `inFlight`, acc, bots, queue pointers, `batchSumValid`, `batchSum`, `batchBots`, `protocolError`, `eccError`.
- Reset mid-batch discards the partial sum and all queued entries. The core is reset in the same window.
- Upstream accept to `isBotValid`: 1 cycle.
- `resultValid` to acc/bots update: 1 cycle.
- Closing result to `batchSumValid`: 2 cycles (1 accumulate + 1 queue write).
- Queue occupancy change to `freezeCore` change: 1 cycle.
- `freezeCore` to `botReady` low: same cycle (combinational).

## Configuration
- `FEEDER_BATCH_COUNT_EN` defined: bots counter and the queue's count field are built; `batchBots` carries the per-batch count.
- Undefined: counter and field are removed, and `batchBots` is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Package `bot_feeder_pkg` holds:
  - `GRAPH_WIDTH=128`, `CONNECT_COUNT_WIDTH=6`, `BATCH_SUM_WIDTH=64`, `BATCH_BOTS_WIDTH=32`;
  - the queue entry struct {sum, bots}.
- Sub-module `batch_result_queue`: a synchronous FIFO with `count` output. The freeze compare lives in the parent.

## Test plan
- Upstream sends a 3-bot batch; core returns connectCounts 0, 1, 5 with last=1 on the third → `batchSum=35`, `batchBots=3`, `inFlight` returns to 0.
- Hold `almostFull=1` for 10 cycles with `botValid=1` → `botReady=0` and `isBotValid=0` throughout; the first issue occurs 1 cycle after deassert.
- Hold `batchSumReady=0` and return 4 one-bot batches → `freezeCore=1` once 2 entries are queued; no issue occurs while frozen; no `protocolError`.
- connectCount=63 twice in one batch → `batchSum=0` (wrap); connectCount=63 once → `batchSum=2^63`.
- `resultValid` with `inFlight=0` → `protocolError=1` sticky, `inFlight` stays 0; issue and result in the same cycle → `inFlight` unchanged.
- Assert `rstN=0` mid-batch with 2 queued entries → all outputs are 0 in the same cycle, queue empty; with `FEEDER_BATCH_COUNT_EN` undefined, `batchBots` is always 0.

Source files
------------

// File: rtl/bot_feeder_pkg.sv
// Shared widths and the batch-result queue entry for the bot stream feeder.
// FEEDER_BATCH_COUNT_EN adds the per-batch bot count field to the entry.
package bot_feeder_pkg;

    localparam int GRAPH_WIDTH         = 128;
    localparam int CONNECT_COUNT_WIDTH = 6;
    localparam int BATCH_SUM_WIDTH     = 64;
    localparam int BATCH_BOTS_WIDTH    = 32;

`ifdef FEEDER_BATCH_COUNT_EN
    typedef struct packed {
        logic [BATCH_SUM_WIDTH-1:0]  sum;
        logic [BATCH_BOTS_WIDTH-1:0] bots;
    } batch_entry_t;
`else
    typedef struct packed {
        logic [BATCH_SUM_WIDTH-1:0] sum;
    } batch_entry_t;
`endif

endpackage

// File: rtl/batch_result_queue.sv
// Synchronous FIFO of closed batch results; push and pop may coincide even
// when full. Entry storage is not reset, only the pointers and occupancy.
module batch_result_queue
    import bot_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  batch_entry_t          push_entry,
    input  logic                  pop,
    output batch_entry_t          head_entry,
    output logic                  empty,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    batch_entry_t          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign rd_en    = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign wr_en    = push && (!full || rd_en);
    assign overflow = push && full && !rd_en;
    assign head_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bot_stream_feeder.sv
// Feeds bot graphs into the connected-count core and folds its results into
// per-batch sums of 2^connectCount. FEEDER_BATCH_COUNT_EN enables batchBots.
module bot_stream_feeder
    import bot_feeder_pkg::*;
#(
    parameter int OUT_QUEUE_DEPTH_LOG2 = 2,
    parameter int FREEZE_MARGIN        = 2,
    parameter int INFLIGHT_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           botValid,
    input  logic [GRAPH_WIDTH-1:0]         botGraph,
    input  logic                           botLast,
    output logic                           botReady,
    output logic                           isBotValid,
    output logic [GRAPH_WIDTH-1:0]         graphIn,
    output logic                           extraDataIn,
    output logic                           freezeCore,
    input  logic                           almostFull,
    input  logic                           resultValid,
    input  logic [CONNECT_COUNT_WIDTH-1:0] connectCount,
    input  logic                           extraDataOut,
    input  logic                           eccStatus,
    output logic                           batchSumValid,
    output logic [BATCH_SUM_WIDTH-1:0]     batchSum,
    output logic [BATCH_BOTS_WIDTH-1:0]    batchBots,
    input  logic                           batchSumReady,
    output logic [INFLIGHT_WIDTH-1:0]      inFlight,
    output logic                           protocolError,
    output logic                           eccError
);

    localparam int QUEUE_DEPTH  = 1 << OUT_QUEUE_DEPTH_LOG2;
    localparam int FREEZE_LEVEL = QUEUE_DEPTH - FREEZE_MARGIN;
    localparam logic [INFLIGHT_WIDTH-1:0] INFLIGHT_ONE = {{(INFLIGHT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [BATCH_SUM_WIDTH-1:0] pow2_term(
        input logic [CONNECT_COUNT_WIDTH-1:0] cc
    );
        return BATCH_SUM_WIDTH'(1) << cc;
    endfunction

    // Saturating at both ends: no wrap past all-ones or below zero.
    function automatic logic [INFLIGHT_WIDTH-1:0] inflight_next(
        input logic [INFLIGHT_WIDTH-1:0] cur,
        input logic                      inc,
        input logic                      dec
    );
        logic [INFLIGHT_WIDTH-1:0] nxt;
        nxt = cur;
        if (inc && !dec && !(&cur)) begin
            nxt = cur + INFLIGHT_ONE;
        end else if (dec && !inc && (cur != '0)) begin
            nxt = cur - INFLIGHT_ONE;
        end
        return nxt;
    endfunction

    logic                             issue_vld_p1;
    logic                             freeze_q;
    logic                             accept;
    logic [BATCH_SUM_WIDTH-1:0]       acc;
    logic [BATCH_SUM_WIDTH-1:0]       acc_sum;
    logic                             close_vld_p1;
    batch_entry_t                     close_entry_p1;
    batch_entry_t                     q_head;
    logic                             q_empty;
    logic                             q_overflow;
    logic                             q_pop;
    logic [OUT_QUEUE_DEPTH_LOG2:0]    q_count;
    logic                             result_underflow;
    logic                             issue_overflow;
`ifdef FEEDER_BATCH_COUNT_EN
    logic [BATCH_BOTS_WIDTH-1:0]      bots;
    logic [BATCH_BOTS_WIDTH-1:0]      bots_sum;

    assign bots_sum = bots + BATCH_BOTS_WIDTH'(1);
`endif

    assign botReady   = !almostFull && !freeze_q;
    assign accept     = botValid && botReady;
    assign freezeCore = freeze_q;
    // A bot accepted on the edge where freeze rises is held back until the
    // core thaws, so the core never sees a bot while frozen.
    assign isBotValid = issue_vld_p1 && !freeze_q;

    assign result_underflow = resultValid && (inFlight == '0);
    assign issue_overflow   = accept && !resultValid && (&inFlight);
    assign acc_sum          = acc + pow2_term(connectCount);

    // ---- issue stage: upstream handshake to core inputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            issue_vld_p1 <= 1'b0;
            graphIn      <= '0;
            extraDataIn  <= 1'b0;
        end else if (accept) begin
            issue_vld_p1 <= 1'b1;
            graphIn      <= botGraph;
            extraDataIn  <= botLast;
        end else if (!freeze_q) begin
            issue_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inFlight      <= '0;
            protocolError <= 1'b0;
            eccError      <= 1'b0;
        end else begin
            inFlight      <= inflight_next(inFlight, accept, resultValid);
            protocolError <= protocolError | result_underflow | issue_overflow | q_overflow;
            eccError      <= eccError | eccStatus;
        end
    end

    // ---- accumulate stage: result to running batch sum / close register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc          <= '0;
            close_vld_p1 <= 1'b0;
`ifdef FEEDER_BATCH_COUNT_EN
            bots         <= '0;
`endif
        end else begin
            close_vld_p1 <= resultValid && extraDataOut;
            if (resultValid) begin
                acc <= extraDataOut ? '0 : acc_sum;
`ifdef FEEDER_BATCH_COUNT_EN
                bots <= extraDataOut ? '0 : bots_sum;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resultValid && extraDataOut) begin
            close_entry_p1.sum <= acc_sum;
`ifdef FEEDER_BATCH_COUNT_EN
            close_entry_p1.bots <= bots_sum;
`endif
        end
    end

    // ---- queue stage: closed batches to the downstream sink
    assign q_pop = !q_empty && batchSumReady;

    batch_result_queue #(
        .DEPTH_LOG2 (OUT_QUEUE_DEPTH_LOG2)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rstN),
        .push       (close_vld_p1),
        .push_entry (close_entry_p1),
        .pop        (q_pop),
        .head_entry (q_head),
        .empty      (q_empty),
        .overflow   (q_overflow),
        .count      (q_count)
    );

    assign batchSumValid = !q_empty;
    assign batchSum      = q_empty ? '0 : q_head.sum;
`ifdef FEEDER_BATCH_COUNT_EN
    assign batchBots     = q_empty ? '0 : q_head.bots;
`else
    assign batchBots     = '0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= (int'(q_count) >= FREEZE_LEVEL);
        end
    end

endmodule

// File: tb/tb_bot_stream_feeder.sv
// Self-checking bench for bot_stream_feeder: directed scenarios plus random
// traffic compared each cycle against a queue-level reference model.
module tb_bot_stream_feeder;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         botValid = 1'b0;
    logic [127:0] botGraph = '0;
    logic         botLast = 1'b0;
    logic         botReady;
    logic         isBotValid;
    logic [127:0] graphIn;
    logic         extraDataIn;
    logic         freezeCore;
    logic         almostFull = 1'b0;
    logic         resultValid = 1'b0;
    logic [5:0]   connectCount = '0;
    logic         extraDataOut = 1'b0;
    logic         eccStatus = 1'b0;
    logic         batchSumValid;
    logic [63:0]  batchSum;
    logic [31:0]  batchBots;
    logic         batchSumReady = 1'b0;
    logic [15:0]  inFlight;
    logic         protocolError;
    logic         eccError;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bot_stream_feeder dut (
        .clk(clk), .rstN(rstN), .botValid(botValid), .botGraph(botGraph),
        .botLast(botLast), .botReady(botReady), .isBotValid(isBotValid),
        .graphIn(graphIn), .extraDataIn(extraDataIn), .freezeCore(freezeCore),
        .almostFull(almostFull), .resultValid(resultValid),
        .connectCount(connectCount), .extraDataOut(extraDataOut),
        .eccStatus(eccStatus), .batchSumValid(batchSumValid), .batchSum(batchSum),
        .batchBots(batchBots), .batchSumReady(batchSumReady), .inFlight(inFlight),
        .protocolError(protocolError), .eccError(eccError)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] sum;
        int unsigned bots;
    } ent_t;

    ent_t         m_q[$];
    bit           m_pend, m_last, m_freeze, m_perr, m_eerr, m_cv;
    logic [127:0] m_graph;
    int unsigned  m_inflight, m_bots, m_cbots;
    logic [63:0]  m_acc, m_csum;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_q.delete();
            m_pend = 0; m_last = 0; m_freeze = 0; m_perr = 0; m_eerr = 0; m_cv = 0;
            m_graph = '0; m_inflight = 0; m_bots = 0; m_cbots = 0;
            m_acc = '0; m_csum = '0;
        end else begin : upd
            bit          take, pop, nf;
            int unsigned sz;
            ent_t        e;
            logic [63:0] s;
            take = botValid && !almostFull && !m_freeze;
            sz   = m_q.size();
            pop  = (sz != 0) && batchSumReady;
            nf   = (DEPTH - sz) <= MARGIN;
            if (take) begin
                m_pend = 1; m_graph = botGraph; m_last = botLast;
            end else if (!m_freeze) begin
                m_pend = 0;
            end
            m_freeze = nf;
            if (resultValid && m_inflight == 0) m_perr = 1;
            if (take && !resultValid) begin
                if (m_inflight == 65535) m_perr = 1;
                else m_inflight++;
            end else if (!take && resultValid && m_inflight != 0) begin
                m_inflight--;
            end
            if (pop) void'(m_q.pop_front());
            if (m_cv) begin
                if (sz == DEPTH && !pop) m_perr = 1;
                else begin
                    e.sum = m_csum; e.bots = m_cbots;
                    m_q.push_back(e);
                end
            end
            m_cv = resultValid && extraDataOut;
            if (resultValid) begin
                s = m_acc + (64'd1 << connectCount);
                if (extraDataOut) begin
                    m_csum = s; m_cbots = m_bots + 1; m_acc = '0; m_bots = 0;
                end else begin
                    m_acc = s; m_bots = m_bots + 1;
                end
            end
            if (eccStatus) m_eerr = 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic [63:0] e_sum;
        logic [31:0] e_bots;
        e_sum  = (m_q.size() != 0) ? m_q[0].sum : 64'd0;
`ifdef FEEDER_BATCH_COUNT_EN
        e_bots = (m_q.size() != 0) ? 32'(m_q[0].bots) : 32'd0;
`else
        e_bots = 32'd0;
`endif
        chk("botReady", botReady, !almostFull && !m_freeze);
        chk("isBotValid", isBotValid, m_pend && !m_freeze);
        chk("graphIn", graphIn, m_graph);
        chk("extraDataIn", extraDataIn, m_last);
        chk("freezeCore", freezeCore, m_freeze);
        chk("inFlight", inFlight, 16'(m_inflight));
        chk("protocolError", protocolError, m_perr);
        chk("eccError", eccError, m_eerr);
        chk("batchSumValid", batchSumValid, m_q.size() != 0);
        chk("batchSum", batchSum, e_sum);
        chk("batchBots", batchBots, e_bots);
        chk("no_issue_frozen", isBotValid && freezeCore, 1'b0);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] g, input logic last);
        botValid = 1; botGraph = g; botLast = last;
        step();
        botValid = 0; botLast = 0;
    endtask

    task automatic result(input logic [5:0] cc, input logic last);
        resultValid = 1; connectCount = cc; extraDataOut = last;
        step();
        resultValid = 0; extraDataOut = 0;
    endtask

    task automatic exp_bots(input string name, input int v);
`ifdef FEEDER_BATCH_COUNT_EN
        chk(name, batchBots, 32'(v));
`else
        chk(name, batchBots, 32'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_isBotValid"}, isBotValid, 0);
        chk({tag, "_graphIn"}, graphIn, 0);
        chk({tag, "_extraDataIn"}, extraDataIn, 0);
        chk({tag, "_freezeCore"}, freezeCore, 0);
        chk({tag, "_inFlight"}, inFlight, 0);
        chk({tag, "_batchSumValid"}, batchSumValid, 0);
        chk({tag, "_batchSum"}, batchSum, 0);
        chk({tag, "_batchBots"}, batchBots, 0);
        chk({tag, "_protocolError"}, protocolError, 0);
        chk({tag, "_eccError"}, eccError, 0);
    endtask

    initial begin
        repeat (3) step();
        check_all_zero("reset");
        rstN = 1;
        step();

        // 3-bot batch, counts 0,1,5 -> 1+2+32
        issue(128'h1111, 0);
        issue(128'h2222, 0);
        issue(128'h3333, 1);
        chk("t1_inflight3", inFlight, 3);
        result(6'd0, 0);
        result(6'd1, 0);
        result(6'd5, 1);
        chk("t1_not_yet", batchSumValid, 0);
        step();
        chk("t1_valid", batchSumValid, 1);
        chk("t1_sum", batchSum, 64'd35);
        exp_bots("t1_bots", 3);
        chk("t1_inflight0", inFlight, 0);
        batchSumReady = 1; step(); batchSumReady = 0;

        // almostFull backpressure
        almostFull = 1; botValid = 1; botGraph = 128'hABCD_0000_1234; botLast = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_ready_low", botReady, 0);
            chk("t2_no_issue", isBotValid, 0);
        end
        almostFull = 0;
        step();
        chk("t2_first_issue", isBotValid, 1);
        chk("t2_graph", graphIn, 128'hABCD_0000_1234);
        botValid = 0; botLast = 0;
        step();
        result(6'd63, 1);
        step();
        chk("t2_sum_2p63", batchSum, 64'h8000_0000_0000_0000);
        exp_bots("t2_bots", 1);
        batchSumReady = 1; step(); batchSumReady = 0;

        // wrap: 2^63 + 2^63 = 0 mod 2^64
        issue(128'h5, 0);
        issue(128'h6, 1);
        result(6'd63, 0);
        result(6'd63, 1);
        step();
        chk("t3_valid", batchSumValid, 1);
        chk("t3_sum_wrap", batchSum, 64'd0);
        exp_bots("t3_bots", 2);
        batchSumReady = 1; step(); batchSumReady = 0;

        // freeze with a stalled sink
        for (int i = 0; i < 4; i++) issue(128'(i + 16), 1);
        for (int i = 0; i < 4; i++) result(6'(i), 1);
        botValid = 1; botGraph = 128'h77;
        repeat (6) step();
        chk("t4_frozen", freezeCore, 1);
        chk("t4_no_issue", isBotValid, 0);
        chk("t4_no_perr", protocolError, 0);
        chk("t4_head_sum", batchSum, 64'd1);
        botValid = 0;
        batchSumReady = 1;
        repeat (6) step();
        batchSumReady = 0;
        chk("t4_thawed", freezeCore, 0);
        chk("t4_drained", batchSumValid, 0);

        // protocol errors and simultaneous issue/result
        result(6'd0, 0);
        chk("t5_perr", protocolError, 1);
        chk("t5_inflight0", inFlight, 0);
        issue(128'h9, 0);
        chk("t5_inflight1", inFlight, 1);
        botValid = 1; botGraph = 128'hA; resultValid = 1; connectCount = 6'd2;
        step();
        botValid = 0; resultValid = 0;
        chk("t5_inflight_same", inFlight, 1);
        chk("t5_perr_sticky", protocolError, 1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            botValid      = ($urandom_range(0, 3) != 0);
            botGraph      = {$urandom, $urandom, $urandom, $urandom};
            botLast       = ($urandom_range(0, 3) == 0);
            almostFull    = ($urandom_range(0, 7) == 0);
            resultValid   = (m_inflight != 0) ? ($urandom_range(0, 2) != 0)
                                              : ($urandom_range(0, 50) == 0);
            connectCount  = 6'($urandom_range(0, 63));
            extraDataOut  = ($urandom_range(0, 3) == 0);
            batchSumReady = ($urandom_range(0, 2) != 0);
            eccStatus     = ($urandom_range(0, 400) == 0);
            step();
        end
        botValid = 0; almostFull = 0; resultValid = 0; extraDataOut = 0;
        batchSumReady = 0; eccStatus = 0;

        // reset mid-batch with two queued entries
        rstN = 0; step(); rstN = 1; step();
        for (int i = 0; i < 3; i++) issue(128'(i + 40), 1);
        result(6'd3, 1);
        result(6'd4, 1);
        result(6'd6, 0);
        step();
        chk("t6_queued_sum", batchSum, 64'd8);
        chk("t6_valid", batchSumValid, 1);
        #2 rstN = 0;
        #1 check_all_zero("midreset");
        step();
        rstN = 1;
        repeat (3) step();
        chk("t6_empty_after", batchSumValid, 0);
        chk("t6_inflight_after", inFlight, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
